stack_alu: RTL and testbench



---
 rtl/stack_alu_if.sv | 22 ++
 rtl/stack_alu.sv | 110 +++++++++++
 tb/tb_stack_alu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/stack_alu_if.sv
// Operation and status bundle between a stack-machine sequencer and stack_alu.
// The master issues opcodes and push data; the slave returns results and flags.
interface stack_alu_if #(
  parameter int WIDTH = 4
);
  logic [2:0]       opcode;
  logic [WIDTH-1:0] input_data;
  logic [WIDTH-1:0] output_data;
  logic             empty;
  logic             full;
  logic             overflow;

  modport master (
    output opcode, input_data,
    input  output_data, empty, full, overflow
  );

  modport slave (
    input  opcode, input_data,
    output output_data, empty, full, overflow
  );
endinterface

// File: rtl/stack_alu.sv
// LIFO stack of signed entries with an in-place add/multiply of the top two entries.
// One opcode per clock; result and signed-overflow flag are registered.
module stack_alu #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  stack_alu_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b100,
    OP_MUL  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } op_t;

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [CW-1:0]            count;
  logic [WIDTH-1:0]         out_q;
  logic                     ovf_q;

  logic [AW-1:0]            push_idx;
  logic [AW-1:0]            top_idx;
  logic [AW-1:0]            below_idx;
  logic signed [WIDTH-1:0]  a;
  logic signed [WIDTH-1:0]  b;
  logic signed [WIDTH:0]    sum;
  logic signed [2*WIDTH-1:0] prod;
  logic                     add_ovf;
  logic                     mul_ovf;
  logic [WIDTH-1:0]         alu_res;
  logic                     alu_ovf;
  logic                     is_empty;
  logic                     is_full;
  logic                     can_arith;
  logic                     is_arith;

  // Index arithmetic wraps modulo DEPTH; a full stack's push slot aliases 0 but is never written.
  assign push_idx  = AW'(count);
  assign top_idx   = AW'(count) - AW'(1);
  assign below_idx = AW'(count) - AW'(2);

  assign a = mem[top_idx];
  assign b = mem[below_idx];

  assign sum  = {b[WIDTH-1], b} + {a[WIDTH-1], a};
  assign prod = (2*WIDTH)'(b) * (2*WIDTH)'(a);

  assign add_ovf = sum[WIDTH] ^ sum[WIDTH-1];
  assign mul_ovf = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});

  assign is_arith = (bus.opcode == OP_ADD) || (bus.opcode == OP_MUL);
  assign alu_res  = (bus.opcode == OP_MUL) ? prod[WIDTH-1:0] : sum[WIDTH-1:0];
  assign alu_ovf  = (bus.opcode == OP_MUL) ? mul_ovf : add_ovf;

  assign is_empty  = (count == '0);
  assign is_full   = (count == CW'(DEPTH));
  assign can_arith = (count >= CW'(2));

  // Storage has no reset; only the count defines which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (bus.opcode == OP_PUSH && !is_full) begin
        mem[push_idx] <= bus.input_data;
      end else if (is_arith && can_arith) begin
        mem[below_idx] <= alu_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (bus.opcode)
        OP_PUSH: begin
          ovf_q <= 1'b0;
          if (!is_full) count <= count + CW'(1);
        end
        OP_POP: begin
          ovf_q <= 1'b0;
          if (!is_empty) begin
            out_q <= a;
            count <= count - CW'(1);
          end
        end
        OP_ADD, OP_MUL: begin
          if (can_arith) begin
            out_q <= alu_res;
            ovf_q <= alu_ovf;
            count <= count - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.output_data = out_q;
  assign bus.overflow    = ovf_q;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
endmodule

// File: tb/tb_stack_alu.sv
// Scoreboard bench for stack_alu: a queue-based reference stack predicts each cycle's outputs.
module tb_stack_alu;
  localparam int DEPTH = 256;
  localparam int WIDTH = 4;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stack_alu_if #(.WIDTH(WIDTH)) bus ();

  stack_alu #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] out;
    logic       ovf;
    logic       empty;
    logic       full;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_stk[$];
  logic [3:0] model_out = 4'h0;
  logic       model_ovf = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int sx(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Reference behaviour: true-integer arithmetic, range check for overflow.
  task automatic modelStep(input logic [2:0] op, input logic [3:0] d);
    int   a;
    int   b;
    int   r;
    exp_t e;
    case (op)
      PUSH: begin
        if (model_stk.size() < DEPTH) model_stk.push_back(d);
        model_ovf = 1'b0;
      end
      POP: begin
        if (model_stk.size() > 0) model_out = model_stk.pop_back();
        model_ovf = 1'b0;
      end
      ADD, MUL: begin
        if (model_stk.size() >= 2) begin
          a = sx(model_stk.pop_back());
          b = sx(model_stk.pop_back());
          r = (op == ADD) ? b + a : b * a;
          model_ovf = (r > 7) || (r < -8);
          model_out = r[3:0];
          model_stk.push_back(model_out);
        end
      end
      default: begin
      end
    endcase
    e.out   = model_out;
    e.ovf   = model_ovf;
    e.empty = (model_stk.size() == 0);
    e.full  = (model_stk.size() == DEPTH);
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [3:0] d);
    exp_t e;
    @(negedge clk);
    bus.opcode     = op;
    bus.input_data = d;
    modelStep(op, d);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput({tag, ".out"},   int'(bus.output_data), int'(e.out));
    checkOutput({tag, ".ovf"},   int'(bus.overflow),    int'(e.ovf));
    checkOutput({tag, ".empty"}, int'(bus.empty),       int'(e.empty));
    checkOutput({tag, ".full"},  int'(bus.full),        int'(e.full));
  endtask

  // Reset is asserted between edges so its asynchronous effect is visible before the next clock.
  task automatic doReset(input string tag);
    @(negedge clk);
    bus.opcode     = NOP;
    bus.input_data = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, ".out"},   int'(bus.output_data), 0);
    checkOutput({tag, ".ovf"},   int'(bus.overflow),    0);
    checkOutput({tag, ".empty"}, int'(bus.empty),       1);
    checkOutput({tag, ".full"},  int'(bus.full),        0);
    model_stk.delete();
    model_out = 4'h0;
    model_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [2:0] rand_ops [5] = '{NOP, PUSH, POP, ADD, MUL};

  initial begin
    bus.opcode     = NOP;
    bus.input_data = 4'h0;

    doReset("reset");
    applyStimulus("idle", NOP, 4'h0);
    applyStimulus("idle2", NOP, 4'h5);

    for (int i = 1; i <= DEPTH + 1; i++) applyStimulus("fill", PUSH, 4'(i));
    for (int i = 0; i <= DEPTH; i++) applyStimulus("drain", POP, 4'h0);

    applyStimulus("add1.push", PUSH, 4'd1);
    applyStimulus("add1.push", PUSH, 4'hE);
    applyStimulus("add1", ADD, 4'h0);

    applyStimulus("mul1.push", PUSH, 4'hE);
    applyStimulus("mul1.push", PUSH, 4'd3);
    applyStimulus("mul1", MUL, 4'h0);

    applyStimulus("addovf.push", PUSH, 4'd7);
    applyStimulus("addovf.push", PUSH, 4'd1);
    applyStimulus("addovf", ADD, 4'h0);
    applyStimulus("ovfhold", NOP, 4'h0);
    applyStimulus("ovfclr.push", PUSH, 4'd2);

    applyStimulus("mulovf.push", PUSH, 4'h9);
    applyStimulus("mulovf.push", PUSH, 4'hE);
    applyStimulus("mulovf", MUL, 4'h0);
    applyStimulus("ovfclr.pop", POP, 4'h0);

    applyStimulus("negmul.push", PUSH, 4'h8);
    applyStimulus("negmul.push", PUSH, 4'hF);
    applyStimulus("negmul", MUL, 4'h0);
    applyStimulus("negadd.push", PUSH, 4'h8);
    applyStimulus("negadd.push", PUSH, 4'hF);
    applyStimulus("negadd", ADD, 4'h0);

    doReset("midreset");
    applyStimulus("single.push", PUSH, 4'd5);
    applyStimulus("single.add", ADD, 4'h0);
    applyStimulus("single.mul", MUL, 4'h0);
    applyStimulus("single.pop", POP, 4'h0);
    applyStimulus("empty.add", ADD, 4'h0);
    applyStimulus("empty.pop", POP, 4'h0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", rand_ops[$urandom_range(4, 0)], 4'($urandom_range(15, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
